apb_reg_slave: RTL and testbench

- APB slave register block. It sits directly downstream of the APB bus interface, consumes the master-side signals, and returns o_prdata, o_pready and o_pslverr.
- Holds a small control/status register file.
- Drives one hardware control line and samples one hardware status line.
- Inserts a programmable number of wait states per transfer and flags illegal accesses through o_pslverr.

---
 rtl/apb_pkg.sv | 20 ++
 rtl/apb_sts_sync.sv | 30 +++
 rtl/apb_reg_slave.sv | 145 ++++++++++++++
 tb/tb_apb_reg_slave.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared defaults, register offsets and FSM state type for the APB register slave.
package apb_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 32;
  localparam int SW_DEF = DW_DEF / 8;

  localparam int unsigned CTRL_OFF    = 'h00;
  localparam int unsigned STATUS_OFF  = 'h04;
  localparam int unsigned SCRATCH_OFF = 'h08;
  localparam int unsigned ID_OFF      = 'h0C;

  localparam logic [31:0] ID_VALUE_DEF = 32'h0A9B_0001;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_state_e;

endpackage

// File: rtl/apb_sts_sync.sv
// Two-flop synchroniser for the external status line with a rising-edge pulse
// taken from the synchronised side.
module apb_sts_sync (
  input  logic pclk,
  input  logic preset,
  input  logic i_sts,
  output logic o_sts_sync,
  output logic o_sts_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_sts;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sts_sync = r_sync;
  assign o_sts_rise = r_sync & ~r_prev;

endmodule

// File: rtl/apb_reg_slave.sv
// APB register slave: CTRL/STATUS/SCRATCH/ID register file with programmable
// wait states and error responses for bad addresses and writes to ID.
module apb_reg_slave
  import apb_pkg::*;
#(
  parameter int             AW          = AW_DEF,
  parameter int             DW          = DW_DEF,
  parameter int             SW          = DW / 8,
  parameter int             WAIT_STATES = 1,
  parameter logic [DW-1:0]  ID_VALUE    = DW'(ID_VALUE_DEF)
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic [AW-1:0] i_paddr,
  input  logic          i_pwrite,
  input  logic          i_psel,
  input  logic          i_penable,
  input  logic [DW-1:0] i_pwdata,
  input  logic [SW-1:0] i_pstrb,
  output logic [DW-1:0] o_prdata,
  output logic          o_pslverr,
  output logic          o_pready,
  output logic          o_hw_ctl,
  input  logic          i_hw_sts
);

  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  apb_state_e    r_state;
  logic [CW-1:0] r_wait_cnt;
  logic [AW-1:0] r_addr;
  logic          r_write;
  logic [DW-1:0] r_wdata;
  logic [SW-1:0] r_strb;

  logic [DW-1:0] r_ctrl;
  logic [DW-1:0] r_scratch;
  logic          r_sticky;

  logic          w_sts_sync;
  logic          w_sts_rise;
  logic          w_complete;
  logic          w_aligned;
  logic          w_hit_ctrl;
  logic          w_hit_status;
  logic          w_hit_scratch;
  logic          w_hit_id;
  logic          w_err;
  logic          w_do_write;
  logic [DW-1:0] w_rdata;

  apb_sts_sync u_sts_sync (
    .pclk       (pclk),
    .preset     (preset),
    .i_sts      (i_hw_sts),
    .o_sts_sync (w_sts_sync),
    .o_sts_rise (w_sts_rise)
  );

  // Setup phase latches the request; a setup seen while still in ACCESS restarts the transfer.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_strb     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_psel && !i_penable) begin
            r_state    <= ACCESS;
            r_wait_cnt <= CW'(WAIT_STATES);
            r_addr     <= i_paddr;
            r_write    <= i_pwrite;
            r_wdata    <= i_pwdata;
            r_strb     <= i_pstrb;
          end
        end
        ACCESS: begin
          if (!i_psel) begin
            r_state <= IDLE;
          end else if (!i_penable) begin
            r_wait_cnt <= CW'(WAIT_STATES);
            r_addr     <= i_paddr;
            r_write    <= i_pwrite;
            r_wdata    <= i_pwdata;
            r_strb     <= i_pstrb;
          end else if (r_wait_cnt != '0) begin
            r_wait_cnt <= r_wait_cnt - CW'(1);
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_complete    = (r_state == ACCESS) && i_psel && i_penable && (r_wait_cnt == '0);
  assign w_aligned     = (r_addr[1:0] == 2'b00);
  assign w_hit_ctrl    = (r_addr == AW'(CTRL_OFF));
  assign w_hit_status  = (r_addr == AW'(STATUS_OFF));
  assign w_hit_scratch = (r_addr == AW'(SCRATCH_OFF));
  assign w_hit_id      = (r_addr == AW'(ID_OFF));
  assign w_err         = !w_aligned
                       || !(w_hit_ctrl || w_hit_status || w_hit_scratch || w_hit_id)
                       || (r_write && w_hit_id);
  assign w_do_write    = w_complete && r_write && !w_err;

  always_comb begin
    w_rdata = '0;
    if (w_hit_ctrl)    w_rdata = r_ctrl;
    if (w_hit_status)  w_rdata = {{(DW-2){1'b0}}, r_sticky, w_sts_sync};
    if (w_hit_scratch) w_rdata = r_scratch;
    if (w_hit_id)      w_rdata = ID_VALUE;
  end

  // Byte-lane writes commit on the completion edge; a sticky set beats a same-cycle W1C.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_ctrl    <= '0;
      r_scratch <= '0;
      r_sticky  <= 1'b0;
    end else begin
      for (int b = 0; b < SW; b++) begin
        if (w_do_write && w_hit_ctrl && r_strb[b])
          r_ctrl[b*8 +: 8] <= r_wdata[b*8 +: 8];
        if (w_do_write && w_hit_scratch && r_strb[b])
          r_scratch[b*8 +: 8] <= r_wdata[b*8 +: 8];
      end
      if (w_sts_rise)
        r_sticky <= 1'b1;
      else if (w_do_write && w_hit_status && r_strb[0] && r_wdata[1])
        r_sticky <= 1'b0;
    end
  end

  assign o_pready  = w_complete;
  assign o_pslverr = w_complete && w_err;
  assign o_prdata  = (w_complete && !r_write && !w_err) ? w_rdata : '0;
  assign o_hw_ctl  = r_ctrl[0];

endmodule

// File: tb/tb_apb_reg_slave.sv
// Self-checking bench: two slaves (1 and 3 wait states) on a shared bus,
// directed scenarios plus a randomized register-map run against a model.
module tb_apb_reg_slave;

  localparam logic [31:0] ID_EXP = 32'h0A9B_0001;

  logic        pclk = 1'b0;
  logic        preset;
  logic [7:0]  paddr;
  logic        pwrite;
  logic [1:0]  psel;
  logic        penable;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        hwSts;
  logic [31:0] prdata [2];
  logic        pready [2];
  logic        pslverr [2];
  logic        hwCtl [2];

  int          checks = 0;
  int          errors = 0;
  int          waitStates [2] = '{1, 3};
  logic        lastCtlAtDone;

  logic [31:0] mCtrl [2];
  logic [31:0] mScratch [2];
  logic        mSticky [2];
  logic        mLive;

  always #5 pclk = ~pclk;

  apb_reg_slave #(.WAIT_STATES(1)) dut (
    .pclk(pclk), .preset(preset), .i_paddr(paddr), .i_pwrite(pwrite),
    .i_psel(psel[0]), .i_penable(penable), .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_prdata(prdata[0]), .o_pslverr(pslverr[0]), .o_pready(pready[0]),
    .o_hw_ctl(hwCtl[0]), .i_hw_sts(hwSts)
  );

  apb_reg_slave #(.WAIT_STATES(3)) dut3 (
    .pclk(pclk), .preset(preset), .i_paddr(paddr), .i_pwrite(pwrite),
    .i_psel(psel[1]), .i_penable(penable), .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_prdata(prdata[1]), .o_pslverr(pslverr[1]), .o_pready(pready[1]),
    .o_hw_ctl(hwCtl[1]), .i_hw_sts(hwSts)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic bit isErr(input logic wr, input logic [7:0] a);
    return (a[1:0] != 2'b00) || !(a inside {8'h00, 8'h04, 8'h08, 8'h0C}) || (wr && a == 8'h0C);
  endfunction

  function automatic logic [31:0] mergeLanes(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] modelRead(input int w, input logic [7:0] a);
    case (a)
      8'h00:   return mCtrl[w];
      8'h04:   return {30'd0, mSticky[w], mLive};
      8'h08:   return mScratch[w];
      8'h0C:   return ID_EXP;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void modelReset();
    for (int w = 0; w < 2; w++) begin
      mCtrl[w] = 0; mScratch[w] = 0; mSticky[w] = 0;
    end
    mLive = 0;
  endfunction

  // One full APB transfer on slave `which`, with completion latency checked.
  task automatic applyStimulus(input int which, input logic wr, input logic [7:0] addr,
                               input logic [31:0] data, input logic [3:0] strb, input bit raiseSts,
                               output logic [31:0] rdata, output logic err);
    int cycles;
    @(posedge pclk); #1;
    psel[which] = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = data; pstrb = strb;
    if (raiseSts) hwSts = 1'b1;
    @(posedge pclk); #1;
    penable = 1'b1;
    cycles = 1;
    @(negedge pclk);
    while (!pready[which] && cycles < 20) begin
      @(posedge pclk); #1;
      cycles++;
      @(negedge pclk);
    end
    checkOutput("pready", 32'(pready[which]), 32'd1);
    checkOutput("latency", 32'(cycles), 32'(waitStates[which] + 1));
    rdata = prdata[which];
    err = pslverr[which];
    lastCtlAtDone = hwCtl[which];
    @(posedge pclk); #1;
    psel[which] = 1'b0; penable = 1'b0;
  endtask

  task automatic doAccess(input int which, input logic wr, input logic [7:0] addr,
                          input logic [31:0] data, input logic [3:0] strb, input string tag);
    logic [31:0] rd;
    logic        er;
    logic        expErr = isErr(wr, addr);
    logic [31:0] expData = (wr || expErr) ? 32'd0 : modelRead(which, addr);
    applyStimulus(which, wr, addr, data, strb, 1'b0, rd, er);
    checkOutput({tag, "-slverr"}, 32'(er), 32'(expErr));
    checkOutput({tag, "-prdata"}, rd, expData);
    if (wr && !expErr) begin
      case (addr)
        8'h00: mCtrl[which] = mergeLanes(mCtrl[which], data, strb);
        8'h04: if (strb[0] && data[1]) mSticky[which] = 1'b0;
        8'h08: mScratch[which] = mergeLanes(mScratch[which], data, strb);
        default: ;
      endcase
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    preset = 1'b1; psel = 2'b00; penable = 1'b0; paddr = '0; pwrite = 1'b0;
    pwdata = '0; pstrb = '0; hwSts = 1'b0;
    modelReset();
    repeat (2) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    checkOutput("reset-pready", 32'(pready[0]), 32'd0);
    checkOutput("reset-hwctl", 32'(hwCtl[0]), 32'd0);

    // Reset values of all four registers
    doAccess(0, 1'b0, 8'h00, 0, 0, "rst-ctrl");
    doAccess(0, 1'b0, 8'h04, 0, 0, "rst-status");
    doAccess(0, 1'b0, 8'h08, 0, 0, "rst-scratch");
    doAccess(0, 1'b0, 8'h0C, 0, 0, "rst-id");

    // Byte-lane write and hw_ctl timing
    doAccess(0, 1'b1, 8'h08, 32'hDEAD_BEEF, 4'b0101, "wr-scratch");
    doAccess(0, 1'b0, 8'h08, 0, 0, "rd-scratch");
    checkOutput("strb-merge", mScratch[0], 32'h00AD_00EF);
    doAccess(0, 1'b1, 8'h00, 32'h1, 4'hF, "wr-ctrl");
    checkOutput("hwctl-at-done", 32'(lastCtlAtDone), 32'd0);
    checkOutput("hwctl-after", 32'(hwCtl[0]), 32'd1);

    // Illegal accesses
    doAccess(0, 1'b1, 8'h0C, 32'h5555_AAAA, 4'hF, "wr-id");
    doAccess(0, 1'b0, 8'h10, 0, 0, "rd-unmapped");
    doAccess(0, 1'b0, 8'h02, 0, 0, "rd-misaligned");
    doAccess(0, 1'b0, 8'h0C, 0, 0, "rd-id-after");

    // Sticky status: pulse, W1C, then set colliding with clear
    @(posedge pclk); #1 hwSts = 1'b1;
    repeat (3) @(posedge pclk);
    #1 hwSts = 1'b0;
    repeat (4) @(posedge pclk);
    mSticky[0] = 1'b1; mSticky[1] = 1'b1;
    doAccess(0, 1'b0, 8'h04, 0, 0, "sts-sticky");
    doAccess(0, 1'b1, 8'h04, 32'h2, 4'h1, "sts-w1c");
    doAccess(0, 1'b0, 8'h04, 0, 0, "sts-cleared");
    applyStimulus(0, 1'b1, 8'h04, 32'h2, 4'h1, 1'b1, rd, er);
    checkOutput("setwins-slverr", 32'(er), 32'd0);
    mSticky[0] = 1'b1; mLive = 1'b1;
    doAccess(0, 1'b0, 8'h04, 0, 0, "sts-setwins");
    @(posedge pclk); #1 hwSts = 1'b0;
    repeat (4) @(posedge pclk);
    mLive = 1'b0;

    // Randomized register-map traffic against the model
    for (int i = 0; i < 40; i++) begin
      int          w = $urandom_range(0, 1);
      int          sel = $urandom_range(0, 5);
      logic [7:0]  a;
      logic [31:0] d = $urandom;
      logic [3:0]  s = 4'($urandom_range(0, 15));
      logic        wr = 1'($urandom_range(0, 1));
      if (sel < 4)       a = 8'(sel * 4);
      else if (sel == 4) a = 8'($urandom_range(0, 255));
      else               a = 8'($urandom_range(0, 3) * 4 + $urandom_range(1, 3));
      doAccess(w, wr, a, d, s, "rand");
      checkOutput("rand-hwctl", 32'(hwCtl[w]), 32'(mCtrl[w][0]));
    end

    // Abort during wait states on the 3-wait slave
    @(posedge pclk); #1;
    psel[1] = 1'b1; penable = 1'b0; paddr = 8'h08; pwrite = 1'b1; pwdata = 32'h1234_5678; pstrb = 4'hF;
    @(posedge pclk); #1 penable = 1'b1;
    @(negedge pclk); checkOutput("abort-wait1", 32'(pready[1]), 32'd0);
    @(posedge pclk); #1;
    @(negedge pclk); checkOutput("abort-wait2", 32'(pready[1]), 32'd0);
    @(posedge pclk); #1 psel[1] = 1'b0;
    @(negedge pclk); checkOutput("abort-dropped", 32'(pready[1]), 32'd0);
    @(posedge pclk); #1 penable = 1'b0;
    @(negedge pclk); checkOutput("abort-idle", 32'(pready[1]), 32'd0);
    doAccess(1, 1'b0, 8'h08, 0, 0, "abort-scratch");

    // Reset in the middle of a transfer
    doAccess(0, 1'b1, 8'h00, 32'h1, 4'hF, "pre-rst-ctrl");
    @(posedge pclk); #1;
    psel[0] = 1'b1; penable = 1'b0; paddr = 8'h08; pwrite = 1'b1; pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1; preset = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b0; psel[0] = 1'b0; penable = 1'b0;
    modelReset();
    @(negedge pclk);
    checkOutput("midrst-pready", 32'(pready[0]), 32'd0);
    checkOutput("midrst-hwctl", 32'(hwCtl[0]), 32'd0);
    doAccess(0, 1'b0, 8'h00, 0, 0, "midrst-ctrl");
    doAccess(0, 1'b0, 8'h04, 0, 0, "midrst-status");
    doAccess(0, 1'b0, 8'h08, 0, 0, "midrst-scratch");
    doAccess(0, 1'b0, 8'h0C, 0, 0, "midrst-id");
    doAccess(1, 1'b0, 8'h08, 0, 0, "midrst-scratch3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
